// File: rtl/btn_pulse_pkg.sv
// Shared types and default parameter values for the push-button pulse generator.
package btn_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int BTN_SYNC_STAGES_DEF     = 2;
  localparam int BTN_DEBOUNCE_CYCLES_DEF = 16;
  localparam int BTN_REPEAT_DELAY_DEF    = 64;
  localparam int BTN_REPEAT_PERIOD_DEF   = 16;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for bringing an asynchronous input into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  // Shift the raw input one stage further along the chain every cycle.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // Chain registers; all stages clear on reset so a held button starts from a known low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronise, debounce, and emit one-cycle enable pulses.
// Optional auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = BTN_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic repeat_active
);

  localparam int             DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          btn_sync;
  btn_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic          entry_pulse;
  logic          rpt_pulse;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (btn_sync)
  );

  // Debounce FSM next state: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    entry_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d     = HELD;
            entry_pulse = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            dcnt_d  = DCNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d     = HELD;
          dcnt_d      = '0;
          entry_pulse = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE_WAIT;
            dcnt_d  = DCNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = HELD;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int            RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW       = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RCNT_ONE = RW'(1);
  localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_active_q, rpt_active_d;
  logic          rpt_hit;

  // Repeat timing: count only while staying in HELD; first wait REPEAT_DELAY, then REPEAT_PERIOD.
  always_comb begin
    rcnt_d       = rcnt_q;
    rpt_active_d = rpt_active_q;
    rpt_hit      = 1'b0;
    if ((state_q == HELD) && (state_d == HELD)) begin
      if (!rpt_active_q) begin
        if (rcnt_q == RD_LAST) begin
          rpt_hit      = 1'b1;
          rpt_active_d = 1'b1;
          rcnt_d       = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_ONE;
        end
      end else if (rcnt_q == RP_LAST) begin
        rpt_hit = 1'b1;
        rcnt_d  = '0;
      end else begin
        rcnt_d = rcnt_q + RCNT_ONE;
      end
    end else begin
      rcnt_d       = '0;
      rpt_active_d = 1'b0;
    end
  end

  // Repeat counter registers, cleared on reset and on every entry into HELD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q       <= '0;
      rpt_active_q <= 1'b0;
    end else begin
      rcnt_q       <= rcnt_d;
      rpt_active_q <= rpt_active_d;
    end
  end

  assign rpt_pulse     = rpt_hit & ~pulse_q;
  assign repeat_active = rpt_active_q;
`else
  assign rpt_pulse     = 1'b0;
  assign repeat_active = 1'b0;
`endif

  // Output decode: level follows the debounced state, pulse merges press and repeat events.
  always_comb begin
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    pulse_d = entry_pulse | rpt_pulse;
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Self-checking bench for btn_pulse_gen; define BTN_AUTO_REPEAT_EN to also exercise auto-repeat.
module tb_btn_pulse_gen;

  logic clk;
  logic rst;
  logic btn_in;
  logic pulse;
  logic level;
  logic repeat_active;

  int   edge_n      = 0;
  int   check_cnt   = 0;
  int   error_cnt   = 0;
  int   pulse_total = 0;
  int   exp_q[$];
  logic [3:0] tb_cnt;

  btn_pulse_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .pulse        (pulse),
    .level        (level),
    .repeat_active(repeat_active)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge index used to timestamp expected and observed pulses.
  always @(posedge clk) edge_n <= edge_n + 1;

  // Downstream 4-bit event counter driven by pulse.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 4'd0;
    else if (pulse) tb_cnt <= tb_cnt + 4'd1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_cnt++;
    if (observed !== expected) begin
      error_cnt++;
      $display("[TB] FAIL %s: observed %0d expected %0d (edge %0d)", tag, observed, expected, edge_n);
    end
  endtask

  task automatic applyStimulus(input logic val, input int cycles);
    btn_in = val;
    repeat (cycles) @(negedge clk);
  endtask

  // Scoreboard: every observed pulse must match the oldest expected edge; overdue entries are misses.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && edge_n > exp_q[0] && !pulse) begin
      checkOutput("missed_pulse", edge_n, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (pulse) begin
      pulse_total++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_pulse", pulse, 0);
      end else begin
        checkOutput("pulse_edge", edge_n, exp_q[0]);
        if (edge_n >= exp_q[0]) void'(exp_q.pop_front());
      end
    end
  end

  int p_edge;
  int start_total;

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_pulse", pulse, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_repeat", repeat_active, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 3);

    $display("[TB] clean press and release");
    exp_q.push_back(edge_n + 6);
    applyStimulus(1'b1, 5);
    checkOutput("press_level_early", level, 0);
    applyStimulus(1'b1, 1);
    checkOutput("press_level", level, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 5);
    checkOutput("release_level_early", level, 1);
    applyStimulus(1'b0, 1);
    checkOutput("release_level", level, 0);
    applyStimulus(1'b0, 4);

    $display("[TB] short bounce");
    applyStimulus(1'b1, 3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1);
      checkOutput("bounce_level", level, 0);
    end

    $display("[TB] low glitch while held");
    exp_q.push_back(edge_n + 6);
    applyStimulus(1'b1, 6);
    checkOutput("glitch_pre_level", level, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1);
      checkOutput("glitch_level", level, 1);
    end
    applyStimulus(1'b0, 8);
    checkOutput("glitch_release_level", level, 0);

    $display("[TB] reset while held");
    exp_q.push_back(edge_n + 6);
    applyStimulus(1'b1, 8);
    checkOutput("held_level", level, 1);
    rst = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("midrst_pulse", pulse, 0);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_repeat", repeat_active, 0);
    rst = 1'b0;
    exp_q.push_back(edge_n + 6);
    applyStimulus(1'b1, 5);
    checkOutput("postrst_level_early", level, 0);
    applyStimulus(1'b1, 1);
    checkOutput("postrst_level", level, 1);
    applyStimulus(1'b0, 8);
    checkOutput("postrst_release", level, 0);

`ifdef BTN_AUTO_REPEAT_EN
    $display("[TB] auto-repeat");
    p_edge = edge_n + 6;
    exp_q.push_back(p_edge);
    exp_q.push_back(p_edge + 8);
    exp_q.push_back(p_edge + 11);
    exp_q.push_back(p_edge + 14);
    exp_q.push_back(p_edge + 17);
    applyStimulus(1'b1, 13);
    checkOutput("repeat_active_early", repeat_active, 0);
    applyStimulus(1'b1, 1);
    checkOutput("repeat_active_rise", repeat_active, 1);
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 2);
    checkOutput("repeat_active_held", repeat_active, 1);
    applyStimulus(1'b0, 1);
    checkOutput("repeat_active_fall", repeat_active, 0);
    applyStimulus(1'b0, 8);
`endif

    $display("[TB] sixteen presses into the counter");
    rst = 1'b1;
    applyStimulus(1'b0, 1);
    rst = 1'b0;
    applyStimulus(1'b0, 2);
    start_total = pulse_total;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(edge_n + 6);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 8);
      if (i == 14) checkOutput("count_at_15", tb_cnt, 15);
    end
    checkOutput("count_wrapped", tb_cnt, 0);
    checkOutput("pulses_16", pulse_total - start_total, 16);

    applyStimulus(1'b0, 20);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

Conditions a raw, asynchronous push-button input into clean single-cycle enable pulses for the 4-bit event counter directly downstream; `pulse` connects to the counter's `en`. The block synchronises the input and debounces it with a small state machine. It emits exactly one pulse per debounced press and exposes the debounced level. An optional auto-repeat feature emits further pulses while the button is held.

## Interface
- `SYNC_STAGES`, 2 — synchroniser depth; legal ≥2.
- `DEBOUNCE_CYCLES`, 16 — consecutive stable samples required to accept a press or a release; legal ≥1.
- `REPEAT_DELAY`, 64 — auto-repeat only: cycles from the initial pulse to the first repeat pulse; legal ≥1.
- `REPEAT_PERIOD`, 16 — auto-repeat only: cycles between repeat pulses; legal ≥1.
- `clk` input 1 — clock.
- `rst` input 1 — reset, synchronous, active-high.
- `btn_in` input 1 — raw button, asynchronous to `clk`, active-high.
- `pulse` output 1 — one-cycle enable pulse, registered.
- `level` output 1 — debounced button level, registered.
- `repeat_active` output 1 — auto-repeat pulses are being generated, registered.

## Operation
- Synchroniser: `SYNC_STAGES` flops; the final stage is `btn_sync`. All flops reset to 0.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Debounce counter `dcnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
- IDLE: if `btn_sync`=1, go to PRESS_WAIT with `dcnt`=1.
- PRESS_WAIT:
  - `btn_sync`=0 → go to IDLE; no pulse.
  - `btn_sync`=1 and `dcnt`==`DEBOUNCE_CYCLES`-1 → go to HELD and set `pulse`=1 for one cycle.
  - Otherwise increment `dcnt`.
  - `DEBOUNCE_CYCLES`=1: go directly from IDLE to HELD on the first high sample.
- HELD: if `btn_sync`=0, go to RELEASE_WAIT with `dcnt`=1.
- RELEASE_WAIT:
  - `btn_sync`=1 → return to HELD; no pulse.
  - `btn_sync`=0 and `dcnt`==`DEBOUNCE_CYCLES`-1 → go to IDLE.
  - Otherwise increment `dcnt`.
- `level` = 1 exactly while the state is HELD or RELEASE_WAIT.
- `pulse` is never high on two consecutive cycles.
- Reset mid-operation: next state is IDLE, counters and outputs are 0, and no pulse is emitted. A button still held after reset is debounced again and produces one new pulse.

## Timing
- Press latency: count the first edge at which `btn_in` is sampled high as edge 0 (input then stable). `pulse` and `level` are high in the cycle following edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1. With defaults this is edge 17; the counter increments at edge 18.
- Release latency: same formula measured from the first low sample; `level` falls in the cycle following that edge.
- Bounce: any high run shorter than `DEBOUNCE_CYCLES` samples produces no pulse and no `level` change.
- Reset values: `pulse`=0, `level`=0, `repeat_active`=0.

## Configuration
- Macro `BTN_AUTO_REPEAT_EN`.
- Defined:
  - In HELD, repeat counter `rcnt` runs. It is cleared on every entry to HELD, including re-entry from RELEASE_WAIT.
  - The first repeat pulse occurs `REPEAT_DELAY` cycles after the entry pulse. Later repeat pulses occur every `REPEAT_PERIOD` cycles.
  - `repeat_active` is set with the first repeat pulse and cleared on leaving HELD.
- Undefined: `rcnt` logic is absent, `repeat_active` is tied to 0, and the `REPEAT_*` parameters are ignored.

## Structure
- Package `btn_pulse_pkg`: FSM state enum typedef `btn_state_t`, default parameter constants.
- Sub-module `sync_ff`: parameterised N-stage 1-bit synchroniser with reset.

## Test plan
- `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4; `btn_in` rises before edge 0 and stays high → `pulse`=1 only in the cycle after edge 5; `level`=1 from then on.
- Same configuration; `btn_in` high for 3 cycles then low → `pulse` and `level` stay 0 throughout.
- Held press, then a 2-cycle low glitch, then high again → no second pulse; `level` stays 1.
- Held press, then `rst` for 1 cycle while still held → outputs 0 next cycle; a new `pulse` appears in the cycle after edge 5 measured from the first post-reset sample.
- `BTN_AUTO_REPEAT_EN` defined, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3, held for 20 cycles after the initial pulse → repeat pulses at +8, +11, +14, +17; `repeat_active` rises at +8.
- Counter downstream, 16 clean presses → count wraps 15→0; exactly 16 pulses observed.
